fetch_arbiter: RTL and testbench

FETCH_ARBITER -- requirements
Module: fetch_arbiter

---
 rtl/fetch_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_fetch_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_arbiter.sv
// fetch_arbiter: shares the single memory bus between instruction fetch and
// data bursts requested by a later pipeline stage, and tracks which PC
// register pair is active across jumps.
//
// Three states: FETCH (bus fetches instructions), DATA (bus runs a burst of
// 1..2^LEN_W-1 cycles), RECOVER (one bubble cycle before fetch resumes).
// All outputs are flops loaded from the next-state decode, so no input has
// a combinational path to any output.
module fetch_arbiter #(
  parameter int LEN_W = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_data_req,
  input  logic             i_data_we,
  input  logic [LEN_W-1:0] i_data_len,
  input  logic             i_jump,
  output logic             o_bus_request,
  output logic             o_fetch_suppress,
  output logic             o_flag_pcraflip,
  output logic             o_load_bus,
  output logic             o_mem_oe,
  output logic             o_mem_we,
  output logic             o_data_ack,
  output logic             o_data_busy
);

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_DATA    = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  localparam logic [LEN_W-1:0] CNT_ZERO = '0;
  localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);

  // State and latched burst fields
  logic [1:0]       r_state;
  logic [LEN_W-1:0] r_cnt;
  logic             r_we_lat;
  logic             r_pending;
  logic             r_flip;

  // Registered outputs
  logic r_bus_request;
  logic r_fetch_suppress;
  logic r_load_bus;
  logic r_mem_oe;
  logic r_mem_we;
  logic r_data_ack;
  logic r_data_busy;

  // Next-state values
  logic [1:0]       w_state_nxt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic             w_we_nxt;
  logic             w_pending_nxt;
  logic             w_flip_nxt;

  // Next-output decode
  logic w_bus_request_nxt;
  logic w_fetch_suppress_nxt;
  logic w_load_bus_nxt;
  logic w_mem_oe_nxt;
  logic w_mem_we_nxt;
  logic w_data_ack_nxt;
  logic w_data_busy_nxt;

  // Next-state logic: burst acceptance, countdown, jump deferral
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_we_nxt      = r_we_lat;
    w_pending_nxt = r_pending;
    w_flip_nxt    = r_flip;
    case (r_state)
      ST_FETCH: begin
        if (i_jump) begin
          // Jump wins; a level-held data_req is picked up next cycle.
          w_flip_nxt = ~r_flip;
        end else if (i_data_req) begin
          w_state_nxt = ST_DATA;
          w_we_nxt    = i_data_we;
          if (i_data_len == CNT_ZERO) begin
            w_cnt_nxt = CNT_ONE;
          end else begin
            w_cnt_nxt = i_data_len;
          end
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DATA: begin
        // Burst inputs are ignored here; only jump is remembered.
        if (i_jump) begin
          w_pending_nxt = 1'b1;
        end else begin
          w_pending_nxt = r_pending;
        end
        w_cnt_nxt = r_cnt - CNT_ONE;
        if (r_cnt <= CNT_ONE) begin
          w_state_nxt = ST_RECOVER;
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_RECOVER: begin
        // Any number of jumps seen while busy collapse into one toggle.
        w_state_nxt   = ST_FETCH;
        w_pending_nxt = 1'b0;
        if (r_pending || i_jump) begin
          w_flip_nxt = ~r_flip;
        end else begin
          w_flip_nxt = r_flip;
        end
      end
      default: begin
        w_state_nxt   = ST_FETCH;
        w_cnt_nxt     = CNT_ZERO;
        w_we_nxt      = 1'b0;
        w_pending_nxt = 1'b0;
      end
    endcase
  end

  // Output decode from the state being entered, so the flops hold state outputs
  always_comb begin
    w_bus_request_nxt    = 1'b0;
    w_fetch_suppress_nxt = 1'b0;
    w_load_bus_nxt       = 1'b1;
    w_mem_oe_nxt         = 1'b1;
    w_mem_we_nxt         = 1'b0;
    w_data_ack_nxt       = 1'b0;
    w_data_busy_nxt      = 1'b0;
    case (w_state_nxt)
      ST_FETCH: begin
        w_bus_request_nxt    = 1'b0;
        w_fetch_suppress_nxt = 1'b0;
        w_load_bus_nxt       = 1'b1;
        w_mem_oe_nxt         = 1'b1;
        w_mem_we_nxt         = 1'b0;
        w_data_ack_nxt       = 1'b0;
        w_data_busy_nxt      = 1'b0;
      end
      ST_DATA: begin
        w_bus_request_nxt    = 1'b1;
        w_fetch_suppress_nxt = 1'b1;
        w_load_bus_nxt       = 1'b0;
        w_mem_oe_nxt         = ~w_we_nxt;
        w_mem_we_nxt         = w_we_nxt;
        w_data_ack_nxt       = (w_cnt_nxt == CNT_ONE);
        w_data_busy_nxt      = 1'b1;
      end
      ST_RECOVER: begin
        // Fetch stage inserts a NOP bubble: not suppressed, nothing loaded.
        w_bus_request_nxt    = 1'b1;
        w_fetch_suppress_nxt = 1'b0;
        w_load_bus_nxt       = 1'b0;
        w_mem_oe_nxt         = 1'b0;
        w_mem_we_nxt         = 1'b0;
        w_data_ack_nxt       = 1'b0;
        w_data_busy_nxt      = 1'b1;
      end
      default: begin
        w_bus_request_nxt    = 1'b0;
        w_fetch_suppress_nxt = 1'b0;
        w_load_bus_nxt       = 1'b1;
        w_mem_oe_nxt         = 1'b1;
        w_mem_we_nxt         = 1'b0;
        w_data_ack_nxt       = 1'b0;
        w_data_busy_nxt      = 1'b0;
      end
    endcase
  end

  // State, latched fields and output flops; reset aborts any burst in flight
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= ST_FETCH;
      r_cnt            <= CNT_ZERO;
      r_we_lat         <= 1'b0;
      r_pending        <= 1'b0;
      r_flip           <= 1'b0;
      r_bus_request    <= 1'b0;
      r_fetch_suppress <= 1'b0;
      r_load_bus       <= 1'b1;
      r_mem_oe         <= 1'b1;
      r_mem_we         <= 1'b0;
      r_data_ack       <= 1'b0;
      r_data_busy      <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_cnt            <= w_cnt_nxt;
      r_we_lat         <= w_we_nxt;
      r_pending        <= w_pending_nxt;
      r_flip           <= w_flip_nxt;
      r_bus_request    <= w_bus_request_nxt;
      r_fetch_suppress <= w_fetch_suppress_nxt;
      r_load_bus       <= w_load_bus_nxt;
      r_mem_oe         <= w_mem_oe_nxt;
      r_mem_we         <= w_mem_we_nxt;
      r_data_ack       <= w_data_ack_nxt;
      r_data_busy      <= w_data_busy_nxt;
    end
  end

  assign o_bus_request    = r_bus_request;
  assign o_fetch_suppress = r_fetch_suppress;
  assign o_flag_pcraflip  = r_flip;
  assign o_load_bus       = r_load_bus;
  assign o_mem_oe         = r_mem_oe;
  assign o_mem_we         = r_mem_we;
  assign o_data_ack       = r_data_ack;
  assign o_data_busy      = r_data_busy;

endmodule

// File: tb/tb_fetch_arbiter.sv
// Bench for fetch_arbiter: directed vectors, a schedule-based reference
// model compared on every cycle, plus hand-computed literal expectations.
module tb_fetch_arbiter;

  logic       clk;
  logic       reset;
  logic       req;
  logic       we;
  logic [1:0] len;
  logic       jmp;

  logic o_bus_request, o_fetch_suppress, o_flag_pcraflip, o_load_bus;
  logic o_mem_oe, o_mem_we, o_data_ack, o_data_busy;

  int errors = 0;
  int checks = 0;

  fetch_arbiter #(.LEN_W(2)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_data_req      (req),
    .i_data_we       (we),
    .i_data_len      (len),
    .i_jump          (jmp),
    .o_bus_request   (o_bus_request),
    .o_fetch_suppress(o_fetch_suppress),
    .o_flag_pcraflip (o_flag_pcraflip),
    .o_load_bus      (o_load_bus),
    .o_mem_oe        (o_mem_oe),
    .o_mem_we        (o_mem_we),
    .o_data_ack      (o_data_ack),
    .o_data_busy     (o_data_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A burst accepted at edge S with length L occupies the outputs after
  // edges S..S+L-1 (DATA), S+L (RECOVER); FETCH otherwise.
  int   m_edge  = 0;
  int   m_start = -100;
  int   m_len   = 1;
  logic m_we    = 1'b0;
  logic m_pend  = 1'b0;
  logic m_flip  = 1'b0;
  logic m_valid = 1'b0;
  logic [7:0] m_exp;

  // 0 = FETCH, 1 = DATA, 2 = RECOVER for the outputs seen after edge x
  function automatic int phase_at(input int x, input int s, input int l);
    if (x >= s && x < s + l) return 1;
    else if (x == s + l) return 2;
    else return 0;
  endfunction

  // Model update on each rising edge from the bench's own stimulus
  always @(posedge clk) begin
    int p;
    m_edge = m_edge + 1;
    if (reset) begin
      m_start = -100;
      m_len   = 1;
      m_we    = 1'b0;
      m_pend  = 1'b0;
      m_flip  = 1'b0;
      m_valid = 1'b1;
    end else begin
      p = phase_at(m_edge - 1, m_start, m_len);
      if (p == 0) begin
        if (jmp) m_flip = ~m_flip;
        else if (req) begin
          m_start = m_edge;
          m_len   = (len == 2'd0) ? 1 : int'(len);
          m_we    = we;
        end
      end else if (p == 1) begin
        if (jmp) m_pend = 1'b1;
      end else begin
        if (jmp || m_pend) m_flip = ~m_flip;
        m_pend = 1'b0;
      end
    end
    p = phase_at(m_edge, m_start, m_len);
    // {bus_request, fetch_suppress, load_bus, mem_oe, mem_we, data_ack, data_busy, flip}
    if (p == 0)      m_exp = {7'b0011000, m_flip};
    else if (p == 1) m_exp = {3'b110, ~m_we, m_we, (m_edge == m_start + m_len - 1), 1'b1, m_flip};
    else             m_exp = {7'b1000001, m_flip};
  end

  // Per-cycle compare of all outputs against the model, away from the edge
  always @(negedge clk) begin
    logic [7:0] act;
    act = {o_bus_request, o_fetch_suppress, o_load_bus, o_mem_oe,
           o_mem_we, o_data_ack, o_data_busy, o_flag_pcraflip};
    if (m_valid) begin
      checks = checks + 1;
      if (act !== m_exp) begin
        errors = errors + 1;
        $display("FAIL model_cmp edge %0d: got %b expected %b", m_edge, act, m_exp);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic r, input logic rq, input logic w,
                     input logic [1:0] l, input logic j);
    reset = r; req = rq; we = w; len = l; jmp = j;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // {rst, req, we, len[1:0], jump}
  logic [5:0] vecs [0:19] = '{
    6'b0_1_0_10_0, 6'b0_0_0_00_0, 6'b0_0_0_00_1, 6'b0_1_1_01_1,
    6'b0_1_1_01_0, 6'b0_0_0_00_0, 6'b0_1_0_11_0, 6'b0_1_0_11_0,
    6'b0_0_1_01_1, 6'b0_0_0_00_0, 6'b0_0_0_00_0, 6'b1_0_0_00_1,
    6'b0_1_1_10_0, 6'b0_0_0_00_0, 6'b0_0_0_00_0, 6'b1_1_0_00_0,
    6'b0_1_0_00_1, 6'b0_0_0_00_0, 6'b0_0_0_00_0, 6'b0_0_0_00_0
  };

  initial begin
    int acks;
    reset = 1'b1; req = 1'b0; we = 1'b0; len = 2'd0; jmp = 1'b0;
    @(negedge clk);
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);

    // Reset then idle: fetch running, flag clear
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      chk("idle_bus_request", o_bus_request, 1'b0);
      chk("idle_fetch_suppress", o_fetch_suppress, 1'b0);
      chk("idle_load_bus", o_load_bus, 1'b1);
      chk("idle_flip", o_flag_pcraflip, 1'b0);
    end

    // Read burst of 3; request changes mid-burst must be ignored
    cyc(1'b0, 1'b1, 1'b0, 2'd3, 1'b0);
    chk("rd3_c1_suppress", o_fetch_suppress, 1'b1);
    chk("rd3_c1_oe", o_mem_oe, 1'b1);
    chk("rd3_c1_ack", o_data_ack, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
    chk("rd3_c2_ack", o_data_ack, 1'b0);
    chk("rd3_c2_we", o_mem_we, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("rd3_c3_ack", o_data_ack, 1'b1);
    chk("rd3_c3_oe", o_mem_oe, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("rd3_rec_bus_request", o_bus_request, 1'b1);
    chk("rd3_rec_suppress", o_fetch_suppress, 1'b0);
    chk("rd3_rec_ack", o_data_ack, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("rd3_fetch_load", o_load_bus, 1'b1);
    chk("rd3_fetch_bus_request", o_bus_request, 1'b0);

    // Held write request with len 0: DATA, RECOVER, FETCH repeating
    acks = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
      acks = acks + int'(o_data_ack);
      chk("wr1_ack", o_data_ack, (i % 3) == 0);
      chk("wr1_mem_we", o_mem_we, (i % 3) == 0);
      chk("wr1_busy", o_data_busy, (i % 3) != 2);
    end
    chk_int("wr1_ack_count", acks, 3);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

    // Jump beats request; two jumps in a burst give one toggle at exit
    cyc(1'b0, 1'b1, 1'b0, 2'd3, 1'b1);
    chk("jmp_flip_set", o_flag_pcraflip, 1'b1);
    chk("jmp_still_fetch", o_load_bus, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 2'd3, 1'b0);
    chk("jmp_data_entered", o_bus_request, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("jmp_mid_flip", o_flag_pcraflip, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("jmp_last_ack", o_data_ack, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("jmp_rec_flip", o_flag_pcraflip, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("jmp_exit_flip", o_flag_pcraflip, 1'b0);

    // Reset mid-burst with a pending jump: abort, no ack, flag cleared
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("rst_pre_flip", o_flag_pcraflip, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 2'd3, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 2'd3, 1'b1);
    chk("rst_load_bus", o_load_bus, 1'b1);
    chk("rst_bus_request", o_bus_request, 1'b0);
    chk("rst_ack", o_data_ack, 1'b0);
    chk("rst_flip", o_flag_pcraflip, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      chk("post_rst_ack", o_data_ack, 1'b0);
      chk("post_rst_flip", o_flag_pcraflip, 1'b0);
      chk("post_rst_bus_request", o_bus_request, 1'b0);
    end

    // Mixed directed table, checked by the model each cycle
    for (int i = 0; i < 20; i++) begin
      cyc(vecs[i][5], vecs[i][4], vecs[i][3], vecs[i][2:1], vecs[i][0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
